// File: rtl/compound_accum_types.sv
// compound_accum_types: FSM states and saturation limits for compound_accum.
//   DATA_W                 - accumulator / operand width
//   CompoundAccum_SECTIONS - st_recv (accepting b_in), st_send (holding a response)
//   ACC_MAX / ACC_MIN      - signed 32-bit clamp values
package compound_accum_types;

   localparam int DATA_W = 32;

   localparam logic signed [DATA_W-1:0] ACC_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [DATA_W-1:0] ACC_MIN = 32'sh8000_0000;

   typedef enum logic [0:0] {
      st_recv = 1'b0,
      st_send = 1'b1
   } CompoundAccum_SECTIONS;

endpackage : compound_accum_types

// File: rtl/testbasic16_types.sv
// testbasic16_types: record types shared by the basic16 producer stage and
// its downstream consumers.
//   CompoundMode - record direction (read / write)
//   CompoundType - {mode, x (32-bit signed), y (bool)}
package testbasic16_types;

   typedef enum logic {
      MODE_READ  = 1'b0,
      MODE_WRITE = 1'b1
   } CompoundMode;

   typedef struct packed {
      CompoundMode       mode;
      logic signed [31:0] x;
      logic              y;
   } CompoundType;

endpackage : testbasic16_types

// File: rtl/compound_accum_alu.sv
// compound_accum_alu: combinational add/subtract of x into the accumulator,
// with overflow detection and optional clamping.
// Ports:
//   acc  (in)  current accumulator value, signed 32-bit
//   x    (in)  operand, signed 32-bit
//   sub  (in)  1 = acc - x, 0 = acc + x
//   nxt  (out) next accumulator value (wrapped or clamped per SATURATE)
//   ovf  (out) 1 when the exact result does not fit in 32 bits
// Parameter SATURATE: 0 = two's-complement wrap, 1 = clamp to ACC_MAX/ACC_MIN.
module compound_accum_alu
   import compound_accum_types::*;
#(
   parameter bit SATURATE = 1'b0
) (
   input  logic signed [DATA_W-1:0] acc,
   input  logic signed [DATA_W-1:0] x,
   input  logic                     sub,
   output logic signed [DATA_W-1:0] nxt,
   output logic                     ovf
);

   logic signed [DATA_W:0] acc_ext;
   logic signed [DATA_W:0] x_ext;
   logic signed [DATA_W:0] sum_ext;

   // Choose between the wrapped low bits and the clamp limit. The sign of
   // the exact (33-bit) result tells which way the overflow went.
   function automatic logic signed [DATA_W-1:0] sat_sel(
      input logic signed [DATA_W:0] full,
      input logic                   overflow,
      input bit                     clamp
   );
      logic signed [DATA_W-1:0] res;
      res = full[DATA_W-1:0];
      if (clamp && overflow) begin
         res = full[DATA_W] ? ACC_MIN : ACC_MAX;
      end
      return res;
   endfunction

   always_comb begin
      acc_ext = {acc[DATA_W-1], acc};
      x_ext   = {x[DATA_W-1], x};
      sum_ext = sub ? (acc_ext - x_ext) : (acc_ext + x_ext);
      // A 33-bit result that fits in 32 bits has its top two bits equal.
      ovf     = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
      nxt     = sat_sel(sum_ext, ovf, SATURATE);
   end

endmodule : compound_accum_alu

// File: rtl/compound_accum.sv
// compound_accum: consumes CompoundType records. Write records add (y=0) or
// subtract (y=1) x into a signed 32-bit accumulator; read records return
// {read, acc, acc==0} on result_out. Both ports use the sync/notify blocking
// handshake: a transfer happens on an edge where sync and notify are both 1.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   b_in              - input record
//   b_in_sync         - upstream has valid data
//   b_in_notify       - this block can accept b_in (registered)
//   result_out        - response record (registered, stable until taken)
//   result_out_sync   - downstream ready for result_out
//   result_out_notify - result_out is valid (registered)
//   op_count          - accepted b_in records, saturating at 16'hFFFF
// Parameter SATURATE: 0 = wrap on overflow, 1 = clamp.
module compound_accum
   import testbasic16_types::*;
   import compound_accum_types::*;
#(
   parameter bit SATURATE = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  CompoundType b_in,
   input  logic        b_in_sync,
   output logic        b_in_notify,
   output CompoundType result_out,
   input  logic        result_out_sync,
   output logic        result_out_notify,
   output logic [15:0] op_count
);

   CompoundAccum_SECTIONS state, state_nxt;

   logic signed [DATA_W-1:0] acc;
   logic signed [DATA_W-1:0] acc_nxt;
   logic signed [DATA_W-1:0] alu_nxt;
   logic                     alu_ovf;

   CompoundType  result_nxt;
   logic         b_in_notify_nxt;
   logic         result_out_notify_nxt;
   logic [15:0]  op_count_nxt;

   logic in_xfer;
   logic out_xfer;

   function automatic logic [15:0] count_sat_inc(input logic [15:0] cnt);
      return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction

   compound_accum_alu #(
      .SATURATE (SATURATE)
   ) u_alu (
      .acc (acc),
      .x   (b_in.x),
      .sub (b_in.y),
      .nxt (alu_nxt),
      .ovf (alu_ovf)
   );

   // Handshakes qualify on the registered notify flags, so nothing on the
   // input side can reach an output without passing through a register.
   assign in_xfer  = b_in_notify && b_in_sync;
   assign out_xfer = result_out_notify && result_out_sync;

   always_comb begin
      state_nxt             = state;
      acc_nxt               = acc;
      result_nxt            = result_out;
      b_in_notify_nxt       = b_in_notify;
      result_out_notify_nxt = result_out_notify;
      op_count_nxt          = op_count;

      case (state)
         st_recv: begin
            if (in_xfer) begin
               op_count_nxt = count_sat_inc(op_count);
               if (b_in.mode == MODE_WRITE) begin
                  acc_nxt = alu_nxt;
               end else begin
                  // acc already holds every earlier write, so a read right
                  // after a write sees that write.
                  result_nxt.mode       = MODE_READ;
                  result_nxt.x          = acc;
                  result_nxt.y          = (acc == '0);
                  b_in_notify_nxt       = 1'b0;
                  result_out_notify_nxt = 1'b1;
                  state_nxt             = st_send;
               end
            end
         end

         st_send: begin
            if (out_xfer) begin
               b_in_notify_nxt       = 1'b1;
               result_out_notify_nxt = 1'b0;
               state_nxt             = st_recv;
            end
         end

         default: begin
            state_nxt             = st_recv;
            b_in_notify_nxt       = 1'b1;
            result_out_notify_nxt = 1'b0;
         end
      endcase
   end

   // Register stage: every output and all state update here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= st_recv;
         acc               <= '0;
         op_count          <= '0;
         b_in_notify       <= 1'b1;
         result_out_notify <= 1'b0;
         result_out.mode   <= MODE_READ;
         result_out.x      <= '0;
         result_out.y      <= 1'b0;
      end else begin
         state             <= state_nxt;
         acc               <= acc_nxt;
         op_count          <= op_count_nxt;
         b_in_notify       <= b_in_notify_nxt;
         result_out_notify <= result_out_notify_nxt;
         result_out        <= result_nxt;
      end
   end

   // The overflow flag is only needed for the clamp decision inside the ALU.
   logic unused_ovf;
   assign unused_ovf = alu_ovf;

endmodule : compound_accum

// File: tb/tb_compound_accum.sv
// Directed bench for compound_accum. Two instances share all stimulus: u_wrap
// (SATURATE=0) and u_sat (SATURATE=1); they only differ on overflow.
module tb_compound_accum;
   import testbasic16_types::*;

   logic        clk = 1'b0;
   logic        rst;
   CompoundType b_in;
   logic        b_in_sync;
   logic        result_out_sync;

   logic        bn_w, bn_s, rn_w, rn_s;
   CompoundType ro_w, ro_s;
   logic [15:0] cnt_w, cnt_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   compound_accum #(.SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .b_in(b_in), .b_in_sync(b_in_sync),
      .b_in_notify(bn_w), .result_out(ro_w), .result_out_sync(result_out_sync),
      .result_out_notify(rn_w), .op_count(cnt_w)
   );

   compound_accum #(.SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .b_in(b_in), .b_in_sync(b_in_sync),
      .b_in_notify(bn_s), .result_out(ro_s), .result_out_sync(result_out_sync),
      .result_out_notify(rn_s), .op_count(cnt_s)
   );

   function automatic CompoundType mk(input CompoundMode m, input logic [31:0] x, input logic y);
      CompoundType r;
      r.mode = m;
      r.x    = x;
      r.y    = y;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input CompoundMode m, input logic [31:0] x, input logic y);
      b_in      = mk(m, x, y);
      b_in_sync = 1'b1;
      step();
      b_in_sync = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      b_in            = mk(MODE_READ, 32'd0, 1'b0);
      b_in_sync       = 1'b0;
      result_out_sync = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_bn",  {63'd0, bn_w}, 64'd1);
      chk("rst_rn",  {63'd0, rn_w}, 64'd0);
      chk("rst_cnt", {48'd0, cnt_w}, 64'd0);
      chk("rst_ro",  {30'd0, ro_w}, {30'd0, mk(MODE_READ, 32'd0, 1'b0)});

      // 5 - 3 = 2, then read
      send(MODE_WRITE, 32'd5, 1'b0);
      chk("wr1_bn", {63'd0, bn_w}, 64'd1);
      send(MODE_WRITE, 32'd3, 1'b1);
      send(MODE_READ, 32'd0, 1'b0);
      chk("rd1_rn",  {63'd0, rn_w}, 64'd1);
      chk("rd1_bn",  {63'd0, bn_w}, 64'd0);
      chk("rd1_ro",  {30'd0, ro_w}, {30'd0, mk(MODE_READ, 32'd2, 1'b0)});
      chk("rd1_cnt", {48'd0, cnt_w}, 64'd3);

      // Downstream stalls 4 cycles; upstream keeps offering a write.
      b_in      = mk(MODE_WRITE, 32'd100, 1'b0);
      b_in_sync = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_bn", {63'd0, bn_w}, 64'd0);
         chk("hold_rn", {63'd0, rn_w}, 64'd1);
         chk("hold_ro", {30'd0, ro_w}, {30'd0, mk(MODE_READ, 32'd2, 1'b0)});
      end
      chk("hold_cnt", {48'd0, cnt_w}, 64'd3);
      b_in_sync       = 1'b0;
      result_out_sync = 1'b1;
      step();
      result_out_sync = 1'b0;
      chk("rel_rn", {63'd0, rn_w}, 64'd0);
      chk("rel_bn", {63'd0, bn_w}, 64'd1);

      // The stalled write must not have reached acc.
      send(MODE_READ, 32'd0, 1'b0);
      chk("rd2_ro",  {30'd0, ro_w}, {30'd0, mk(MODE_READ, 32'd2, 1'b0)});
      chk("rd2_cnt", {48'd0, cnt_w}, 64'd4);
      result_out_sync = 1'b1;
      step();
      result_out_sync = 1'b0;

      // +7 then -7 back to back, read with downstream already ready
      do_reset();
      send(MODE_WRITE, 32'd7, 1'b0);
      chk("b2b_bn", {63'd0, bn_w}, 64'd1);
      send(MODE_WRITE, 32'd7, 1'b1);
      chk("b2b_cnt", {48'd0, cnt_w}, 64'd2);
      result_out_sync = 1'b1;
      send(MODE_READ, 32'd0, 1'b0);
      chk("zero_rn", {63'd0, rn_w}, 64'd1);
      chk("zero_ro", {30'd0, ro_w}, {30'd0, mk(MODE_READ, 32'd0, 1'b1)});
      step();
      chk("rt_rn", {63'd0, rn_w}, 64'd0);
      chk("rt_bn", {63'd0, bn_w}, 64'd1);
      result_out_sync = 1'b0;

      // Positive overflow: MAX + 1
      do_reset();
      send(MODE_WRITE, 32'h7FFF_FFFF, 1'b0);
      send(MODE_WRITE, 32'd1, 1'b0);
      send(MODE_READ, 32'd0, 1'b0);
      chk("povf_wrap", {30'd0, ro_w}, {30'd0, mk(MODE_READ, 32'h8000_0000, 1'b0)});
      chk("povf_sat",  {30'd0, ro_s}, {30'd0, mk(MODE_READ, 32'h7FFF_FFFF, 1'b0)});

      // Negative overflow: MIN - 1
      do_reset();
      send(MODE_WRITE, 32'h8000_0000, 1'b0);
      send(MODE_WRITE, 32'd1, 1'b1);
      send(MODE_READ, 32'd0, 1'b0);
      chk("novf_wrap", {30'd0, ro_w}, {30'd0, mk(MODE_READ, 32'h7FFF_FFFF, 1'b0)});
      chk("novf_sat",  {30'd0, ro_s}, {30'd0, mk(MODE_READ, 32'h8000_0000, 1'b0)});

      // Reset while a response is pending
      do_reset();
      send(MODE_WRITE, 32'd9, 1'b0);
      send(MODE_READ, 32'd0, 1'b0);
      chk("pend_rn", {63'd0, rn_w}, 64'd1);
      do_reset();
      chk("mrst_rn",  {63'd0, rn_w}, 64'd0);
      chk("mrst_bn",  {63'd0, bn_w}, 64'd1);
      chk("mrst_cnt", {48'd0, cnt_w}, 64'd0);
      send(MODE_READ, 32'd0, 1'b0);
      chk("mrst_ro",  {30'd0, ro_w}, {30'd0, mk(MODE_READ, 32'd0, 1'b1)});
      chk("mrst_cnt1", {48'd0, cnt_w}, 64'd1);
      result_out_sync = 1'b1;
      step();
      result_out_sync = 1'b0;

      // op_count saturation over 70000 consecutive writes
      do_reset();
      b_in      = mk(MODE_WRITE, 32'd0, 1'b0);
      b_in_sync = 1'b1;
      repeat (65534) step();
      chk("cnt_fffe", {48'd0, cnt_w}, 64'h0000_0000_0000_FFFE);
      repeat (4466) step();
      b_in_sync = 1'b0;
      chk("cnt_sat_w", {48'd0, cnt_w}, 64'h0000_0000_0000_FFFF);
      chk("cnt_sat_s", {48'd0, cnt_s}, 64'h0000_0000_0000_FFFF);
      chk("cnt_sat_bn", {63'd0, bn_w}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_compound_accum

// File: doc/compound_accum.md
# compound_accum

Downstream consumer of the `CompoundType` stream produced on `b_out` by the basic16 stage. Write-mode records add or subtract `x` into a 32-bit signed accumulator. Read-mode records return the current accumulator value as a `CompoundType` on a second blocking output. Both sides use the codebase's sync/notify blocking-port handshake, so the block drops in directly behind the producer.

## Interface
- `SATURATE`, default 0: 0 = two's-complement wrap on overflow; 1 = clamp to signed 32-bit min/max.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `b_in`  input  `CompoundType`  record from upstream: `mode` (read/write), `x` (32-bit signed), `y` (bool).
- `b_in_sync`  input  1  upstream has valid data on `b_in`.
- `b_in_notify`  output  1  this block is ready to accept `b_in`.
- `result_out`  output  `CompoundType`  response record.
- `result_out_sync`  input  1  downstream is ready to take `result_out`.
- `result_out_notify`  output  1  `result_out` holds valid data.
- `op_count`  output  16  number of accepted input records, saturating at 16'hFFFF.

## Operation
- Transfer rule on either port: a transfer happens in a cycle where `notify` and `sync` are both 1 at the rising edge. A `sync` pulse while `notify` is 0 is ignored and nothing is consumed.
- States, enum `CompoundAccum_SECTIONS`:
  - `st_recv`: `b_in_notify` = 1 and `result_out_notify` = 0.
  - `st_send`: `b_in_notify` = 0 and `result_out_notify` = 1.
- In `st_recv`, on a `b_in` transfer with `mode` = write:
  - if `y` = 0: `acc <= acc + x`;
  - if `y` = 1: `acc <= acc - x`.
  - Overflow follows `SATURATE`.
  - The block stays in `st_recv` with `b_in_notify` held at 1, so it accepts one write per cycle back-to-back.
- In `st_recv`, on a `b_in` transfer with `mode` = read:
  - the block registers `result_out` = {`mode` = read, `x` = acc, `y` = (acc == 0)};
  - `b_in_notify <= 0`, `result_out_notify <= 1`, next state `st_send`.
  - `acc` is unchanged.
- In `st_send`:
  - `result_out` is held stable until the transfer.
  - On a `result_out` transfer: `result_out_notify <= 0`, `b_in_notify <= 1`, next state `st_recv`.
- `op_count` increments on every `b_in` transfer, read or write, and saturates at 16'hFFFF.
- Overflow detection: the sum/difference is computed in 33 bits. Overflow is flagged when the sign of the 33-bit result differs from bit 31 of the truncated 32-bit result.
  - Wrap mode keeps the low 32 bits.
  - Saturate mode selects 32'h7FFFFFFF on positive overflow and 32'h80000000 on negative overflow.
- Reset values: state `st_recv`, `acc` = 0, `op_count` = 0, `b_in_notify` = 1, `result_out_notify` = 0, `result_out` = {read, 0, 1'b0}.
- Reset mid-operation (including while in `st_send` with a pending response) drops the pending response and restores all reset values. The pending response is not replayed.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Write throughput is 1 record per cycle.
- Read response latency: `result_out_notify` rises on the first edge after the read transfer, so the response is visible in the following cycle.
- Minimum read round-trip is 2 cycles: accept, then hand off. If `result_out_sync` is already high, the response transfers in the first `st_send` cycle.
- A read that immediately follows a write sees the accumulator after that write has been applied.
- `b_in` is accepted again on the edge after the `result_out` transfer, so a stream of reads alternates 1 accept cycle with 1 send cycle.
- `b_in_sync` while in `st_send` has no effect; the upstream stage holds its data.

## Structure
- The `CompoundType` struct and its mode enum come from the existing `testbasic16_types` package. They are not redefined here.
- New package `compound_accum_types` holds the `CompoundAccum_SECTIONS` enum and the saturation constants `ACC_MAX` and `ACC_MIN`.
- One sub-module, `compound_accum_alu`: purely combinational. Inputs: `acc`, `x`, `sub`, and the `SATURATE` parameter. Outputs: next accumulator value and an overflow flag. The FSM and all registers stay in `compound_accum`.

## Test plan
- Reset, then writes {write, 5, 0}, {write, 3, 1}, then read {read, 0, 0} → `result_out` = {read, 2, 0}, `result_out_notify` high 1 cycle after the read is accepted, `op_count` = 3.
- Hold `result_out_sync` = 0 for 4 cycles after a read → `b_in_notify` stays 0, `result_out` stays stable, `b_in` is ignored. Raise sync → transfer occurs, and `b_in_notify` = 1 on the next cycle.
- `SATURATE` = 1: write {write, 32'h7FFFFFFF, 0}, then write {write, 1, 0}, then read → `x` = 32'h7FFFFFFF. Repeat with `SATURATE` = 0 → `x` = 32'h80000000.
- Writes of +7 and -7 (the second as {write, 7, 1}), then read → `result_out` = {read, 0, 1}. Back-to-back writes are accepted on consecutive cycles.
- Assert `rst` while in `st_send` → next cycle: `result_out_notify` = 0, `b_in_notify` = 1, `acc` = 0, `op_count` = 0. A subsequent read returns {read, 0, 1}.
- Hold `b_in_sync` high for 70000 write cycles → `op_count` saturates at 16'hFFFF.
